// File: rtl/cache_fill_arbiter.sv
// Miss arbiter/fill controller: grants one I- or D-cache miss at a time and bursts its block from memory.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN starts the burst at the missed word instead of word 0.
module cache_fill_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic [5:0]        fill_index,
  output logic [2:0]        fill_word,
  output logic [15:0]       fill_data,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              fill_done_i,
  output logic              fill_done_d,
  output logic              busy
);
  localparam int OFF_W = $clog2(WORDS);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_gnt_q;
  logic              r_last_gnt;
  logic [OFF_W-1:0]  r_issue_cnt;
  logic [OFF_W-1:0]  r_ret_cnt;

  logic              w_any_req;
  logic              w_pick_d;
  logic              w_grant;
  logic              w_ret;
  logic              w_last_issue;
  logic              w_last_ret;
  logic [OFF_W-1:0]  w_start;
  logic [OFF_W-1:0]  w_iss_off;
  logic [OFF_W-1:0]  w_ret_off;
  logic [1:0]        w_gnt_oh;
  logic [1:0]        w_fill_we;
  logic [1:0]        w_tag_we;
  logic              w_unused_lsbs;

  // Round-robin: on a tie the cache not granted last wins (r_last_gnt: 0=I, 1=D).
  assign w_any_req    = i_miss | d_miss;
  assign w_pick_d     = d_miss & (~i_miss | ~r_last_gnt);
  assign w_grant      = (r_state == S_IDLE) & w_any_req;
  assign w_ret        = mem_data_valid & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
  assign w_last_issue = mem_en & (r_issue_cnt == LAST_OFF);
  assign w_last_ret   = w_ret & (r_ret_cnt == LAST_OFF);

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  assign w_start = r_addr_q[OFF_W:1];
`else
  assign w_start = '0;
`endif

  assign w_iss_off     = w_start + r_issue_cnt;
  assign w_ret_off     = w_start + r_ret_cnt;
  assign w_unused_lsbs = ^r_addr_q[OFF_W:0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cache
    assign w_gnt_oh[gi] = (gi == 0) ? ~r_gnt_q : r_gnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_state_next = w_last_ret ? S_DONE : S_DRAIN;
      S_DRAIN: if (w_last_ret) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    busy      = 1'b0;
    w_fill_we = 2'b00;
    w_tag_we  = 2'b00;
    case (r_state)
      S_ISSUE: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        busy     = 1'b1;
        w_tag_we = w_gnt_oh;
      end
      default: ;
    endcase
    if (w_ret) w_fill_we = w_gnt_oh;
  end

  // Reset leaves r_last_gnt pointing at I so the first tie goes to D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q    <= '0;
      r_gnt_q     <= 1'b0;
      r_last_gnt  <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_addr_q    <= w_pick_d ? d_miss_addr : i_miss_addr;
        r_gnt_q     <= w_pick_d;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end
      if (mem_en) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_ret) r_ret_cnt <= r_ret_cnt + 1'b1;
      if (r_state == S_DONE) r_last_gnt <= r_gnt_q;
    end
  end

  assign mem_addr    = mem_en ? {r_addr_q[ADDR_W-1:OFF_W+1], w_iss_off, 1'b0} : '0;
  assign fill_index  = r_addr_q[9:4];
  assign fill_word   = w_ret ? 3'(w_ret_off) : 3'd0;
  assign fill_data   = mem_data;
  assign fill_we_i   = w_fill_we[0];
  assign fill_we_d   = w_fill_we[1];
  assign tag_we_i    = w_tag_we[0];
  assign tag_we_d    = w_tag_we[1];
  assign fill_done_i = w_tag_we[0];
  assign fill_done_d = w_tag_we[1];

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency (4-cycle) in-order memory model.
module tb_cache_fill_arbiter;
  localparam int WORDS  = 8;
  localparam int ADDR_W = 16;
  localparam int LAT    = 4;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_miss, d_miss;
  logic [ADDR_W-1:0] i_miss_addr, d_miss_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [15:0]       mem_data;
  logic [5:0]        fill_index;
  logic [2:0]        fill_word;
  logic [15:0]       fill_data;
  logic              fill_we_i, fill_we_d, tag_we_i, tag_we_d, fill_done_i, fill_done_d, busy;

  cache_fill_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: each issued address comes back LAT cycles later with data = addr ^ 16'h5A5A.
  logic [LAT-1:0] pipe_v = '0;
  logic [15:0]    pipe_a [LAT];
  logic           stray_v = 1'b0;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], mem_en};
    pipe_a[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) pipe_a[k] <= pipe_a[k-1];
  end

  assign mem_data_valid = pipe_v[LAT-1] | stray_v;
  assign mem_data       = pipe_v[LAT-1] ? (pipe_a[LAT-1] ^ 16'h5A5A) : 16'hDEAD;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  logic [15:0] q_addr[$];
  int          q_addr_cyc[$];
  int          q_word[$];
  int          q_word_cyc[$];
  logic [15:0] q_data[$];
  int n_we_i, n_we_d, n_tag_i, n_tag_d, done_i, done_d, idx_seen;

  // Caller sets requests on a negedge while the DUT is IDLE; the next posedge is cycle 0.
  task automatic observe(input int ncyc, input int drop_i_after);
    q_addr.delete(); q_addr_cyc.delete(); q_word.delete(); q_word_cyc.delete(); q_data.delete();
    n_we_i = 0; n_we_d = 0; n_tag_i = 0; n_tag_d = 0; done_i = -1; done_d = -1; idx_seen = -1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (mem_en) begin
        q_addr.push_back(mem_addr);
        q_addr_cyc.push_back(c);
      end
      if (fill_we_i) n_we_i++;
      if (fill_we_d) n_we_d++;
      if (fill_we_i | fill_we_d) begin
        q_word.push_back(int'(fill_word));
        q_word_cyc.push_back(c);
        q_data.push_back(fill_data);
      end
      if (tag_we_i) n_tag_i++;
      if (tag_we_d) n_tag_d++;
      if (fill_done_i) begin done_i = c; i_miss = 1'b0; end
      if (fill_done_d) begin done_d = c; d_miss = 1'b0; end
      if (c == 2) idx_seen = int'(fill_index);
      if (c == drop_i_after) i_miss = 1'b0;
    end
    $display("fill: idx=%0d issues=%0d we_i=%0d we_d=%0d done_i@%0d done_d@%0d",
             idx_seen, q_addr.size(), n_we_i, n_we_d, done_i, done_d);
  endtask

  task automatic expect_fill(input string tag, input bit want_d, input int want_idx);
    chk({tag, "_idx"}, idx_seen, want_idx);
    chk({tag, "_issues"}, q_addr.size(), WORDS);
    if (want_d) begin
      chk({tag, "_done_d"}, done_d, 13);
      chk({tag, "_we_d"}, n_we_d, WORDS);
      chk({tag, "_tag_d"}, n_tag_d, 1);
      chk({tag, "_other"}, n_we_i + n_tag_i + ((done_i < 0) ? 0 : 1), 0);
    end else begin
      chk({tag, "_done_i"}, done_i, 13);
      chk({tag, "_we_i"}, n_we_i, WORDS);
      chk({tag, "_tag_i"}, n_tag_i, 1);
      chk({tag, "_other"}, n_we_d + n_tag_d + ((done_d < 0) ? 0 : 1), 0);
    end
  endtask

  initial begin
    int start;
    int off;
    int n_str;
    int n_vld;
    int n_bsy;
    logic [15:0] want_a;

    rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; i_miss_addr = '0; d_miss_addr = '0;
    #1;
    chk("rst_outputs", {mem_en, busy, fill_we_i, fill_we_d, tag_we_i, tag_we_d, fill_done_i, fill_done_d}, 0);
    chk("rst_index", fill_index, 0);
    chk("rst_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous pair straight out of reset: D first, then I.
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8000;
    observe(14, 0);
    expect_fill("tie1_d", 1'b1, 0);
    // I still pending and a new D miss arrives together: I wins this time.
    d_miss = 1'b1; d_miss_addr = 16'h8010;
    observe(14, 0);
    expect_fill("tie2_i", 1'b0, 4);
    // Next tie goes back to D.
    i_miss = 1'b1; i_miss_addr = 16'h0050;
    observe(14, 0);
    expect_fill("tie3_d", 1'b1, 1);
    // Pending I is served with its request dropped after cycle 3.
    observe(14, 3);
    expect_fill("drop_i", 1'b0, 5);

    // Single D miss at 0x1234.
    d_miss = 1'b1; d_miss_addr = 16'h1234;
    observe(14, 0);
    expect_fill("single", 1'b1, 35);
    start = CWF ? 2 : 0;
    for (int k = 0; k < q_addr.size(); k++) begin
      off = (start + k) % WORDS;
      want_a = 16'h1230 + 16'(2 * off);
      chk($sformatf("single_maddr%0d", k), q_addr[k], want_a);
      chk($sformatf("single_mcyc%0d", k), q_addr_cyc[k], k + 1);
    end
    chk("single_words", q_word.size(), WORDS);
    for (int k = 0; k < q_word.size(); k++) begin
      off = (start + k) % WORDS;
      want_a = 16'h1230 + 16'(2 * off);
      chk($sformatf("single_word%0d", k), q_word[k], off);
      chk($sformatf("single_wcyc%0d", k), q_word_cyc[k], k + 5);
      chk($sformatf("single_data%0d", k), q_data[k], want_a ^ 16'h5A5A);
    end

    // Reset at cycle 6 of a fill, released at cycle 8, late returns still arriving.
    d_miss = 1'b1; d_miss_addr = 16'h2468;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; d_miss = 1'b0;
    #1;
    chk("midrst_outputs", {mem_en, busy, fill_we_i, fill_we_d, tag_we_i, tag_we_d, fill_done_i, fill_done_d}, 0);
    chk("midrst_index", fill_index, 0);
    chk("midrst_addr", mem_addr, 0);
    n_str = 0; n_vld = 0; n_bsy = 0;
    for (int c = 6; c <= 12; c++) begin
      if (c > 6) @(negedge clk);
      if (mem_data_valid) n_vld++;
      if (fill_we_i | fill_we_d | tag_we_i | tag_we_d | fill_done_i | fill_done_d) n_str++;
      if (busy) n_bsy++;
      if (c == 8) rst = 1'b0;
    end
    chk("midrst_late_valids", n_vld, 4);
    chk("midrst_strobes", n_str, 0);
    chk("midrst_busy", n_bsy, 0);
    d_miss = 1'b1; d_miss_addr = 16'h1234;
    observe(14, 0);
    expect_fill("after_rst", 1'b1, 35);

    // Stray valid while IDLE.
    stray_v = 1'b1;
    #1;
    chk("stray_we", {fill_we_i, fill_we_d}, 0);
    @(negedge clk);
    chk("stray_tag_busy", {tag_we_i, tag_we_d, busy}, 0);
    stray_v = 1'b0;
    @(negedge clk);
    chk("stray_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
